// File: rtl/h264invdcdequant.sv
// Inverse 2x2 chroma DC Hadamard with flat-matrix dequantisation.
// Four levels in, four dequantised DC coefficients out, one per cycle.
module h264invdcdequant #(
    parameter bit TOGETHER = 1'b0
) (
    input  logic               CLK2,
    input  logic               RESET,
    output logic               READYI,
    input  logic               ENABLE,
    input  logic signed [15:0] ZIN,
    input  logic        [5:0]  QP,
    output logic               VALID,
    output logic signed [15:0] YYOUT,
    input  logic               READYO
);

    typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

    state_t state, state_nx;

    logic        [1:0]  in_cnt, out_cnt;
    logic signed [15:0] c [4];
    logic signed [17:0] f [4];
    logic        [3:0]  qp_div;
    logic        [2:0]  qp_mod;

    logic               accept, launch;
    logic        [5:0]  qp_c;
    logic        [3:0]  div_lu;
    logic        [2:0]  mod_lu;
    logic signed [17:0] a0, a1, a2, a3;
    logic signed [17:0] f_sel;
    logic signed [31:0] fe, ve, prod, scaled;
    logic signed [5:0]  v;
    logic signed [15:0] dq;

    assign READYI = (state == LOAD) && !RESET;
    assign accept = ENABLE && READYI;
    assign launch = (state == OUT) &&
                    (READYO || (TOGETHER && out_cnt != 2'd0));

    // qp/6 and qp%6 via a comparator ladder rather than a divider
    always_comb begin
        qp_c   = (QP > 6'd51) ? 6'd51 : QP;
        div_lu = 4'd0;
        for (int i = 1; i <= 8; i++) begin
            if (qp_c >= 6'(6 * i)) div_lu = 4'(i);
        end
        mod_lu = 3'(qp_c - 6'(6 * div_lu));
    end

    always_comb begin
        a0 = 18'(c[0]);
        a1 = 18'(c[1]);
        a2 = 18'(c[2]);
        a3 = 18'(c[3]);
    end

    always_comb begin
        f_sel = f[out_cnt];
        case (qp_mod)
            3'd0:    v = 6'sd10;
            3'd1:    v = 6'sd11;
            3'd2:    v = 6'sd13;
            3'd3:    v = 6'sd14;
            3'd4:    v = 6'sd16;
            default: v = 6'sd18;
        endcase
        fe     = 32'(f_sel);
        ve     = 32'(v);
        prod   = fe * ve;
        scaled = (prod <<< qp_div) >>> 1;
        if (scaled > 32'sd32767)
            dq = 16'sh7fff;
        else if (scaled < -32'sd32768)
            dq = 16'sh8000;
        else
            dq = scaled[15:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (accept && in_cnt == 2'd3) state_nx = COMPUTE;
            COMPUTE: state_nx = OUT;
            OUT:     if (launch && out_cnt == 2'd3) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) state <= LOAD;
        else       state <= state_nx;
    end

    always_ff @(posedge CLK2 or posedge RESET) begin
        if (RESET) begin
            in_cnt  <= 2'd0;
            out_cnt <= 2'd0;
            qp_div  <= 4'd0;
            qp_mod  <= 3'd0;
            VALID   <= 1'b0;
            YYOUT   <= 16'sd0;
            for (int i = 0; i < 4; i++) begin
                c[i] <= 16'sd0;
                f[i] <= 18'sd0;
            end
        end else begin
            VALID <= 1'b0;
            if (accept) begin
                c[in_cnt] <= ZIN;
                in_cnt    <= in_cnt + 2'd1;
                if (in_cnt == 2'd0) begin
                    qp_div <= div_lu;
                    qp_mod <= mod_lu;
                end
            end
            if (state == COMPUTE) begin
                f[0] <= a0 + a1 + a2 + a3;
                f[1] <= a0 - a1 + a2 - a3;
                f[2] <= a0 + a1 - a2 - a3;
                f[3] <= a0 - a1 - a2 + a3;
            end
            if (launch) begin
                YYOUT   <= dq;
                VALID   <= 1'b1;
                out_cnt <= out_cnt + 2'd1;
                if (out_cnt == 2'd3) in_cnt <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_h264invdcdequant.sv
// Directed bench for h264invdcdequant: one instance per TOGETHER setting,
// shared stimulus, per-instance checks.
module tb_h264invdcdequant;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic               rdy_o = 1'b1;
    logic signed [15:0] zin = '0;
    logic        [5:0]  qp = '0;
    logic               ra, rb, va, vb;
    logic signed [15:0] ya, yb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    h264invdcdequant #(.TOGETHER(1'b0)) dut_a (
        .CLK2(clk), .RESET(rst), .READYI(ra), .ENABLE(en),
        .ZIN(zin), .QP(qp), .VALID(va), .YYOUT(ya), .READYO(rdy_o)
    );

    h264invdcdequant #(.TOGETHER(1'b1)) dut_b (
        .CLK2(clk), .RESET(rst), .READYI(rb), .ENABLE(en),
        .ZIN(zin), .QP(qp), .VALID(vb), .YYOUT(yb), .READYO(rdy_o)
    );

    typedef struct packed {
        logic [5:0]       qp;
        logic [3:0][15:0] z;
        logic [3:0][15:0] e;
    } vec_t;

    function automatic vec_t mk(int q, int z0, int z1, int z2, int z3,
                                int e0, int e1, int e2, int e3);
        vec_t r;
        r.qp   = 6'(q);
        r.z[0] = 16'(z0);
        r.z[1] = 16'(z1);
        r.z[2] = 16'(z2);
        r.z[3] = 16'(z3);
        r.e[0] = 16'(e0);
        r.e[1] = 16'(e1);
        r.e[2] = 16'(e2);
        r.e[3] = 16'(e3);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] z, input logic [5:0] q,
                        input bit hold);
        int n;
        n = 0;
        zin = z;
        qp  = q;
        en  = 1'b1;
        while (!ra && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", int'(ra), 1);
        @(posedge clk);
        #1;
        if (hold) zin = 16'sd999;
        else      en = 1'b0;
    endtask

    task automatic collect(input vec_t v, input string tag);
        int ka, kb, j, first;
        ka = 0; kb = 0; j = 0; first = -1;
        while ((ka < 4 || kb < 4) && j < 40) begin
            @(negedge clk);
            if (va) begin
                if (ka < 4)
                    chk($sformatf("%s_a%0d", tag, ka), int'(ya),
                        int'($signed(v.e[ka])));
                if (ka == 0) first = j;
                ka++;
            end
            if (vb) begin
                if (kb < 4)
                    chk($sformatf("%s_b%0d", tag, kb), int'(yb),
                        int'($signed(v.e[kb])));
                kb++;
            end
            if (ka >= 4) en = 1'b0;
            j++;
        end
        chk({tag, "_cnt_a"}, ka, 4);
        chk({tag, "_cnt_b"}, kb, 4);
        chk({tag, "_lat"}, first, 2);
    endtask

    task automatic load_block(input vec_t v, input bit hold_last);
        push(v.z[0], v.qp, 1'b0);
        push(v.z[1], 6'd63, 1'b0);
        push(v.z[2], 6'd63, 1'b0);
        push(v.z[3], 6'd63, hold_last);
    endtask

    vec_t vecs [8];
    vec_t tv;
    logic [9:0] hv_a, hv_b, hr_a, hr_b;
    int ka, kb, n;

    initial begin
        vecs[0] = mk(0, 1, 0, 0, 0, 5, 5, 5, 5);
        vecs[1] = mk(0, 0, 1, 0, 0, 5, -5, 5, -5);
        vecs[2] = mk(28, 2, 1, 0, 0, 384, 128, 384, 128);
        vecs[3] = mk(51, 32767, 32767, 32767, 32767, 32767, 0, 0, 0);
        vecs[4] = mk(60, 32767, 32767, 32767, 32767, 32767, 0, 0, 0);
        vecs[5] = mk(51, -32768, -32768, -32768, -32768, -32768, 0, 0, 0);
        vecs[6] = mk(1, -1, 0, 0, 0, -6, -6, -6, -6);
        vecs[7] = mk(17, 3, 1, 2, 0, 216, 144, 72, 0);

        @(negedge clk);
        @(negedge clk);
        chk("rst_readyi_a", int'(ra), 0);
        chk("rst_readyi_b", int'(rb), 0);
        chk("rst_valid_a", int'(va), 0);
        chk("rst_yyout_a", int'(ya), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_readyi_a", int'(ra), 1);

        for (int i = 0; i < 8; i++) begin
            load_block(vecs[i], 1'b0);
            collect(vecs[i], $sformatf("vec%0d", i));
        end

        // READYO pattern 1,0,0,1,0,1,1 during OUT
        rdy_o = 1'b0;
        tv = vecs[7];
        load_block(tv, 1'b0);
        @(negedge clk);
        @(negedge clk);
        ka = 0; kb = 0;
        for (int j = 0; j < 10; j++) begin
            case (j)
                0, 3, 5, 6: rdy_o = 1'b1;
                default:    rdy_o = 1'b0;
            endcase
            @(negedge clk);
            hv_a[j] = va;
            hv_b[j] = vb;
            hr_a[j] = ra;
            hr_b[j] = rb;
            if (va && ka < 4) begin
                chk($sformatf("tog_a%0d", ka), int'(ya),
                    int'($signed(tv.e[ka])));
                ka++;
            end
            if (vb && kb < 4) begin
                chk($sformatf("tog_b%0d", kb), int'(yb),
                    int'($signed(tv.e[kb])));
                kb++;
            end
        end
        chk("tog_valid_a", int'(hv_a), int'(10'b0001101001));
        chk("tog_valid_b", int'(hv_b), int'(10'b0000001111));
        chk("tog_readyi_a", int'(hr_a), int'(10'b1111000000));
        chk("tog_readyi_b", int'(hr_b), int'(10'b1111111000));
        rdy_o = 1'b1;

        // reset in the middle of an output burst
        load_block(mk(0, 100, 0, 0, 0, 500, 500, 500, 500), 1'b0);
        n = 0;
        while (!va && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_seen", int'(va), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid_a", int'(va), 0);
        chk("midrst_valid_b", int'(vb), 0);
        chk("midrst_yyout_a", int'(ya), 0);
        chk("midrst_readyi_a", int'(ra), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset after two levels of a block
        push(16'sd7, 6'd0, 1'b0);
        push(16'sd7, 6'd63, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("partrst_valid_a", int'(va), 0);
        chk("partrst_yyout_b", int'(yb), 0);
        rst = 1'b0;
        @(negedge clk);
        load_block(vecs[0], 1'b0);
        collect(vecs[0], "after_rst");

        // ENABLE held high through COMPUTE and OUT
        load_block(vecs[2], 1'b1);
        collect(vecs[2], "hold");
        chk("hold_readyi_a", int'(ra), 1);
        load_block(vecs[1], 1'b0);
        collect(vecs[1], "post_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
